round_seq_ctrl: RTL and testbench

- Sequencing controller for the 24-bit-output stream round datapath.
- Accepts one job (32-bit seed, 96-bit key, 96-bit IV, word count) over a valid/ready handshake.
- Drives the datapath's `rst`/`start`/`init`/`k`/`p` pins through warm-up and stream phases, then forwards the datapath output `y` as a qualified keystream.
- The datapath can neither pause nor re-seed except through its asynchronous reset, so this block owns that reset and holds the datapath in reset whenever no job is active.

---
 rtl/round_seq_ctrl_pkg.sv | 38 +++
 rtl/round_seq_ctrl.sv | 168 ++++++++++++++++
 tb/tb_round_seq_ctrl.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/round_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : round_seq_ctrl_pkg
// Description : Shared constants, state encoding and key/IV word selection
//               for the stream round sequencing controller.
// Revision    : 1.0 - initial release
// ============================================================================
package round_seq_ctrl_pkg;

  localparam int KEY_WORDS = 4;
  localparam int WORD_W    = 24;
  localparam int SEED_W    = 32;

  // Controller state encoding
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_ARM    = 3'd1;
  localparam state_t ST_WARM   = 3'd2;
  localparam state_t ST_STREAM = 3'd3;
  localparam state_t ST_DONE   = 3'd4;

  // Pick word idx out of a packed 4-word key or IV vector (word 0 in the LSBs)
  function automatic logic [WORD_W-1:0] sel_word(
    input logic [KEY_WORDS*WORD_W-1:0] vec,
    input logic [1:0]                  idx
  );
    logic [WORD_W-1:0] w;
    case (idx)
      2'd0:    w = vec[WORD_W-1:0];
      2'd1:    w = vec[2*WORD_W-1:WORD_W];
      2'd2:    w = vec[3*WORD_W-1:2*WORD_W];
      default: w = vec[4*WORD_W-1:3*WORD_W];
    endcase
    return w;
  endfunction

endpackage : round_seq_ctrl_pkg
`default_nettype wire

// File: rtl/round_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : round_seq_ctrl
// Description : Sequences one keystream job through the round datapath:
//               owns the datapath reset, drives start/init/k/p through the
//               warm-up and stream phases and qualifies the datapath output.
// Revision    : 1.0 - initial release
// ============================================================================
module round_seq_ctrl
  import round_seq_ctrl_pkg::*;
#(
  parameter int INIT_ROUNDS = 64,
  parameter int LEN_W       = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [SEED_W-1:0]           req_seed,
  input  logic [KEY_WORDS*WORD_W-1:0] req_key,
  input  logic [KEY_WORDS*WORD_W-1:0] req_iv,
  input  logic [LEN_W-1:0]            req_len,
  input  logic                        abort,
  output logic                        dp_rst,
  output logic                        dp_start,
  output logic [SEED_W-1:0]           dp_init,
  output logic [WORD_W-1:0]           dp_k,
  output logic [WORD_W-1:0]           dp_p,
  input  logic [WORD_W-1:0]           dp_y,
  output logic                        ks_valid,
  output logic [WORD_W-1:0]           ks_data,
  output logic                        ks_last,
  output logic                        busy,
  output logic                        done,
  output logic                        aborted
);

  // Round counter is wide enough that it never wraps within a job; only
  // its two LSBs select the key/IV word.
  localparam int                 RND_W    = $clog2(INIT_ROUNDS) + LEN_W;
  localparam logic [RND_W-1:0]   RND_LAST = RND_W'(INIT_ROUNDS - 1);
  localparam logic [LEN_W-1:0]   LEN_ONE  = LEN_W'(1);

  state_t                        state_q, state_d;
  logic [SEED_W-1:0]             seed_q;
  logic [KEY_WORDS*WORD_W-1:0]   key_q;
  logic [KEY_WORDS*WORD_W-1:0]   iv_q;
  logic [LEN_W-1:0]              len_q;
  logic [RND_W-1:0]              rnd_q, rnd_d;
  logic [LEN_W-1:0]              wcnt_q, wcnt_d;
  logic                          aborted_q, aborted_d;
  logic                          dp_rst_q;

  logic                          accept;
  logic                          active;

  assign accept = (state_q == ST_IDLE) && req_valid;
  assign active = (state_q == ST_ARM) || (state_q == ST_WARM) ||
                  (state_q == ST_STREAM);

  // Next-state and counter logic; abort overrides the normal flow
  always_comb begin
    state_d   = state_q;
    rnd_d     = rnd_q;
    wcnt_d    = wcnt_q;
    aborted_d = aborted_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d   = ST_ARM;
          aborted_d = 1'b0;
        end
      end
      ST_ARM: begin
        rnd_d   = '0;
        wcnt_d  = '0;
        state_d = ST_WARM;
      end
      ST_WARM: begin
        rnd_d = rnd_q + RND_W'(1);
        if (rnd_q == RND_LAST) begin
          state_d = (len_q != '0) ? ST_STREAM : ST_DONE;
        end
      end
      ST_STREAM: begin
        rnd_d  = rnd_q + RND_W'(1);
        wcnt_d = wcnt_q + LEN_ONE;
        if (wcnt_q == (len_q - LEN_ONE)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        rnd_d   = '0;
        wcnt_d  = '0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (abort && active) begin
      state_d   = ST_DONE;
      aborted_d = 1'b1;
    end
  end

  // Control state, counters and registered datapath reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rnd_q     <= '0;
      wcnt_q    <= '0;
      aborted_q <= 1'b0;
      dp_rst_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      rnd_q     <= rnd_d;
      wcnt_q    <= wcnt_d;
      aborted_q <= aborted_d;
      // Datapath runs only while the next state is a working state
      dp_rst_q  <= !((state_d == ST_ARM) || (state_d == ST_WARM) ||
                     (state_d == ST_STREAM));
    end
  end

  // Job parameters captured at the accept edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seed_q <= '0;
      key_q  <= '0;
      iv_q   <= '0;
      len_q  <= '0;
    end else if (accept) begin
      seed_q <= req_seed;
      key_q  <= req_key;
      iv_q   <= req_iv;
      len_q  <= req_len;
    end
  end

  // Output decode from the current state; keystream is a pass-through of dp_y
  always_comb begin
    req_ready = (state_q == ST_IDLE);
    dp_rst    = dp_rst_q;
    dp_start  = (state_q == ST_ARM);
    dp_init   = (state_q == ST_ARM) ? seed_q : '0;
    dp_k      = '0;
    dp_p      = '0;
    ks_valid  = 1'b0;
    ks_data   = '0;
    ks_last   = 1'b0;
    busy      = (state_q != ST_IDLE);
    done      = (state_q == ST_DONE);
    aborted   = (state_q == ST_DONE) && aborted_q;
    if (state_q == ST_WARM) begin
      dp_k = sel_word(key_q, rnd_q[1:0]);
      dp_p = sel_word(iv_q, rnd_q[1:0]);
    end
    if (state_q == ST_STREAM) begin
      dp_k     = sel_word(key_q, rnd_q[1:0]);
      ks_valid = 1'b1;
      ks_data  = dp_y;
      ks_last  = (wcnt_q == (len_q - LEN_ONE));
    end
  end

endmodule : round_seq_ctrl
`default_nettype wire

// File: tb/tb_round_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_round_seq_ctrl
// Description : Self-checking bench for round_seq_ctrl with a behavioural
//               round datapath and a keystream reference computed from the
//               job parameters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_round_seq_ctrl;

  localparam int INIT = 4;
  localparam int LW   = 16;
  localparam int NREC = 64;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [31:0]   req_seed;
  logic [95:0]   req_key;
  logic [95:0]   req_iv;
  logic [LW-1:0] req_len;
  logic          abort;
  logic          dp_rst;
  logic          dp_start;
  logic [31:0]   dp_init;
  logic [23:0]   dp_k;
  logic [23:0]   dp_p;
  logic [23:0]   dp_y;
  logic          ks_valid;
  logic [23:0]   ks_data;
  logic          ks_last;
  logic          busy;
  logic          done;
  logic          aborted;

  int checks = 0;
  int errors = 0;

  round_seq_ctrl #(.INIT_ROUNDS(INIT), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_seed(req_seed), .req_key(req_key), .req_iv(req_iv), .req_len(req_len),
    .abort(abort),
    .dp_rst(dp_rst), .dp_start(dp_start), .dp_init(dp_init),
    .dp_k(dp_k), .dp_p(dp_p), .dp_y(dp_y),
    .ks_valid(ks_valid), .ks_data(ks_data), .ks_last(ks_last),
    .busy(busy), .done(done), .aborted(aborted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural round datapath
  function automatic logic [31:0] rnd_fn(input logic [31:0] s, input logic [23:0] k,
                                         input logic [23:0] p);
    return ({s[26:0], s[31:27]} ^ {8'h5A, k}) + {p, 8'h3C};
  endfunction
  function automatic logic [23:0] out_fn(input logic [31:0] s);
    return s[31:8] ^ s[23:0];
  endfunction
  function automatic logic [23:0] word(input logic [95:0] v, input int idx);
    return v[idx*24 +: 24];
  endfunction

  logic [31:0] dp_s;
  always @(posedge clk or posedge dp_rst) begin
    if (dp_rst)        dp_s <= 32'h0;
    else if (dp_start) dp_s <= dp_init;
    else               dp_s <= rnd_fn(dp_s, dp_k, dp_p);
  end
  assign dp_y = out_fn(dp_s);

  // Reference keystream: INIT warm-up rounds with IV, then one word per round
  logic [23:0] exp_ks [NREC];
  task automatic build_exp(input int len);
    logic [31:0] s;
    s = req_seed;
    for (int r = 0; r < INIT + len; r++) begin
      if (r >= INIT) exp_ks[r - INIT] = out_fn(s);
      s = rnd_fn(s, word(req_key, r % 4), (r < INIT) ? word(req_iv, r % 4) : 24'h0);
    end
  endtask

  task automatic randomize_job();
    req_seed = $urandom;
    req_key  = {$urandom, $urandom, $urandom};
    req_iv   = {$urandom, $urandom, $urandom};
  endtask

  // Per-cycle trace (cycle 1 = ARM of the first accepted job)
  logic        r_start [NREC];
  logic [31:0] r_init  [NREC];
  logic [23:0] r_k     [NREC];
  logic [23:0] r_p     [NREC];
  logic        r_valid [NREC];
  logic [23:0] r_data  [NREC];
  logic        r_last  [NREC];
  logic        r_done  [NREC];
  logic        r_abt   [NREC];
  logic        r_ready [NREC];
  logic        r_dprst [NREC];
  logic        r_busy  [NREC];
  logic        s_valid, s_dprst, s_ready, s_busy, s_done;
  logic [23:0] s_k;

  // Drives one request from an idle negedge and records ncyc cycles
  task automatic run_job(input int len, input int abort_cyc, input int rel_cyc,
                         input int rst_cyc, input int ncyc);
    req_len   = len[LW-1:0];
    req_valid = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      r_start[c] = dp_start; r_init[c] = dp_init; r_k[c] = dp_k; r_p[c] = dp_p;
      r_valid[c] = ks_valid; r_data[c] = ks_data; r_last[c] = ks_last;
      r_done[c] = done; r_abt[c] = aborted; r_ready[c] = req_ready;
      r_dprst[c] = dp_rst; r_busy[c] = busy;
      abort = (c == abort_cyc);
      if (c == rel_cyc) req_valid = 1'b0;
      if (c == rst_cyc) begin
        rst = 1'b1;
        #1;
        s_valid = ks_valid; s_dprst = dp_rst; s_ready = req_ready;
        s_busy = busy; s_done = done; s_k = dp_k;
      end else if (rst) begin
        rst = 1'b0;
      end
    end
    abort = 1'b0; req_valid = 1'b0; rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; abort = 1'b0;
    req_seed = '0; req_key = '0; req_iv = '0; req_len = '0;
    repeat (3) @(negedge clk);
    checks++; if (dp_rst !== 1'b1) begin errors++; $display("FAIL reset_dp_rst got %b exp 1", dp_rst); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
    checks++; if ({ks_valid, done, busy, dp_start, aborted, ks_last} !== 6'b0) begin
      errors++; $display("FAIL reset_flags got %b exp 000000", {ks_valid, done, busy, dp_start, aborted, ks_last}); end
    checks++; if ({dp_init, dp_k, dp_p, ks_data} !== 104'h0) begin
      errors++; $display("FAIL reset_buses got %h exp 0", {dp_init, dp_k, dp_p, ks_data}); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if ({req_ready, busy, dp_rst} !== 3'b101) begin
      errors++; $display("FAIL reset_release got %b exp 101", {req_ready, busy, dp_rst}); end
  endtask

  task automatic test_normal(input int len);
    logic e_arm, e_warm, e_str, e_done, e_idle;
    logic [23:0] ek, ep;
    randomize_job();
    build_exp(len);
    run_job(len, 0, 1, 0, INIT + len + 4);
    for (int c = 1; c <= INIT + len + 4; c++) begin
      e_arm  = (c == 1);
      e_warm = (c >= 2) && (c <= INIT + 1);
      e_str  = (c >= INIT + 2) && (c <= INIT + 1 + len);
      e_done = (c == INIT + 2 + len);
      e_idle = (c > INIT + 2 + len);
      ek = (e_warm || e_str) ? word(req_key, (c - 2) % 4) : 24'h0;
      ep = e_warm ? word(req_iv, (c - 2) % 4) : 24'h0;
      checks++; if (r_start[c] !== e_arm) begin errors++; $display("FAIL start len=%0d c=%0d got %b exp %b", len, c, r_start[c], e_arm); end
      if (e_arm) begin
        checks++; if (r_init[c] !== req_seed) begin errors++; $display("FAIL init c=%0d got %h exp %h", c, r_init[c], req_seed); end
      end
      checks++; if (r_k[c] !== ek) begin errors++; $display("FAIL dp_k len=%0d c=%0d got %h exp %h", len, c, r_k[c], ek); end
      checks++; if (r_p[c] !== ep) begin errors++; $display("FAIL dp_p len=%0d c=%0d got %h exp %h", len, c, r_p[c], ep); end
      checks++; if (r_valid[c] !== e_str) begin errors++; $display("FAIL ks_valid len=%0d c=%0d got %b exp %b", len, c, r_valid[c], e_str); end
      if (e_str) begin
        checks++; if (r_data[c] !== exp_ks[c - INIT - 2]) begin
          errors++; $display("FAIL ks_data len=%0d c=%0d got %h exp %h", len, c, r_data[c], exp_ks[c - INIT - 2]); end
      end
      checks++; if (r_last[c] !== (len != 0 && c == INIT + 1 + len)) begin
        errors++; $display("FAIL ks_last len=%0d c=%0d got %b", len, c, r_last[c]); end
      checks++; if (r_done[c] !== e_done) begin errors++; $display("FAIL done len=%0d c=%0d got %b exp %b", len, c, r_done[c], e_done); end
      checks++; if (r_abt[c] !== 1'b0) begin errors++; $display("FAIL aborted len=%0d c=%0d got %b exp 0", len, c, r_abt[c]); end
      checks++; if (r_ready[c] !== e_idle) begin errors++; $display("FAIL req_ready len=%0d c=%0d got %b exp %b", len, c, r_ready[c], e_idle); end
      checks++; if (r_dprst[c] !== (e_done || e_idle)) begin errors++; $display("FAIL dp_rst len=%0d c=%0d got %b", len, c, r_dprst[c]); end
      checks++; if (r_busy[c] !== !e_idle) begin errors++; $display("FAIL busy len=%0d c=%0d got %b", len, c, r_busy[c]); end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_abort();
    randomize_job();
    build_exp(3);
    run_job(3, 3, 1, 0, 8);
    for (int c = 1; c <= 8; c++) begin
      checks++; if (r_done[c] !== (c == 4)) begin errors++; $display("FAIL abort_done c=%0d got %b", c, r_done[c]); end
      checks++; if (r_abt[c] !== (c == 4)) begin errors++; $display("FAIL abort_flag c=%0d got %b", c, r_abt[c]); end
      checks++; if (r_dprst[c] !== (c >= 4)) begin errors++; $display("FAIL abort_dp_rst c=%0d got %b", c, r_dprst[c]); end
      checks++; if (r_valid[c] !== 1'b0) begin errors++; $display("FAIL abort_ks_valid c=%0d got %b exp 0", c, r_valid[c]); end
      checks++; if (r_ready[c] !== (c >= 5)) begin errors++; $display("FAIL abort_ready c=%0d got %b", c, r_ready[c]); end
    end
    repeat (2) @(negedge clk);
    run_job(3, 0, 1, 0, 10);
    for (int c = 1; c <= 10; c++) begin
      checks++; if (r_valid[c] !== (c >= 6 && c <= 8)) begin errors++; $display("FAIL rerun_valid c=%0d got %b", c, r_valid[c]); end
      if (c >= 6 && c <= 8) begin
        checks++; if (r_data[c] !== exp_ks[c - 6]) begin errors++; $display("FAIL rerun_data c=%0d got %h exp %h", c, r_data[c], exp_ks[c - 6]); end
      end
      checks++; if (r_abt[c] !== 1'b0) begin errors++; $display("FAIL rerun_aborted c=%0d got %b exp 0", c, r_abt[c]); end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic e_str;
    randomize_job();
    build_exp(3);
    run_job(3, 0, 11, 0, 20);
    for (int c = 1; c <= 20; c++) begin
      e_str = (c >= 6 && c <= 8) || (c >= 16 && c <= 18);
      checks++; if (r_start[c] !== (c == 1 || c == 11)) begin errors++; $display("FAIL b2b_start c=%0d got %b", c, r_start[c]); end
      checks++; if (r_ready[c] !== (c == 10 || c == 20)) begin errors++; $display("FAIL b2b_ready c=%0d got %b", c, r_ready[c]); end
      checks++; if (r_done[c] !== (c == 9 || c == 19)) begin errors++; $display("FAIL b2b_done c=%0d got %b", c, r_done[c]); end
      checks++; if (r_valid[c] !== e_str) begin errors++; $display("FAIL b2b_valid c=%0d got %b exp %b", c, r_valid[c], e_str); end
      if (e_str) begin
        checks++; if (r_data[c] !== exp_ks[(c < 10) ? c - 6 : c - 16]) begin
          errors++; $display("FAIL b2b_data c=%0d got %h exp %h", c, r_data[c], exp_ks[(c < 10) ? c - 6 : c - 16]); end
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_async_reset();
    randomize_job();
    build_exp(3);
    run_job(3, 0, 1, 7, 12);
    checks++; if (r_valid[7] !== 1'b1) begin errors++; $display("FAIL arst_pre_valid got %b exp 1", r_valid[7]); end
    checks++; if (r_data[7] !== exp_ks[1]) begin errors++; $display("FAIL arst_pre_data got %h exp %h", r_data[7], exp_ks[1]); end
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL arst_ks_valid got %b exp 0", s_valid); end
    checks++; if (s_dprst !== 1'b1) begin errors++; $display("FAIL arst_dp_rst got %b exp 1", s_dprst); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL arst_ready got %b exp 1", s_ready); end
    checks++; if ({s_busy, s_done} !== 2'b00) begin errors++; $display("FAIL arst_busy_done got %b exp 00", {s_busy, s_done}); end
    checks++; if (s_k !== 24'h0) begin errors++; $display("FAIL arst_dp_k got %h exp 0", s_k); end
    for (int c = 8; c <= 12; c++) begin
      checks++; if ({r_done[c], r_busy[c], r_valid[c]} !== 3'b000) begin
        errors++; $display("FAIL arst_after c=%0d got %b exp 000", c, {r_done[c], r_busy[c], r_valid[c]}); end
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_normal(3);
    test_normal(0);
    test_normal(int'($urandom_range(1, 6)));
    test_normal(1);
    test_abort();
    test_back_to_back();
    test_async_reset();
    test_normal(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_round_seq_ctrl
`default_nettype wire
